// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side push port and decode-side valid/ready head port of the fetch queue.
interface fetch_queue_if #(parameter int PTR_WIDTH = 2);
  logic                 flush;
  logic                 in_valid;
  logic [31:0]          in_instruction;
  logic [31:0]          in_pcIncr;
  logic [31:0]          in_pcJump;
  logic                 fetch_stall;
  logic                 out_valid;
  logic [31:0]          out_instruction;
  logic [31:0]          out_pcIncr;
  logic [31:0]          out_pcJump;
  logic                 decode_ready;
  logic [PTR_WIDTH:0]   occupancy;
  modport slave (
    input  flush, in_valid, in_instruction, in_pcIncr, in_pcJump, decode_ready,
    output fetch_stall, out_valid, out_instruction, out_pcIncr, out_pcJump, occupancy
  );
  modport master (
    output flush, in_valid, in_instruction, in_pcIncr, in_pcJump, decode_ready,
    input  fetch_stall, out_valid, out_instruction, out_pcIncr, out_pcJump, occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between fetch and decode with full back-pressure and flush.
module fetch_queue #(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input logic            clock,
  input logic            reset,
  fetch_queue_if.slave   bus
);
  logic [95:0]          mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [PTR_WIDTH:0]   count;
  logic                 push, pop;
  assign bus.fetch_stall = count == (PTR_WIDTH+1)'(DEPTH);
  assign bus.out_valid   = count != '0;
  assign bus.occupancy   = count;
  assign {bus.out_instruction, bus.out_pcIncr, bus.out_pcJump} = mem[rd_ptr];
  // stall comes from registered count only, so decode_ready never reaches fetch_stall
  assign push = bus.in_valid && !bus.fetch_stall && !bus.flush;
  assign pop  = bus.out_valid && bus.decode_ready && !bus.flush;
  always_ff @(posedge clock)
    if (push && !reset) mem[wr_ptr] <= {bus.in_instruction, bus.in_pcIncr, bus.in_pcJump};
  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);
    end
  end
  count_ok: assert property (@(posedge clock) disable iff (reset)
    count <= (PTR_WIDTH+1)'(DEPTH) && !(pop && count == '0))
    else $fatal(1, "CERR fetch_queue count=%0d pop=%0b", count, pop);
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue covering fill, full stall, stream wrap, flush and reset.
module tb_fetch_queue;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  fetch_queue_if #(.PTR_WIDTH(2)) bus ();
  fetch_queue #(.DEPTH(4), .PTR_WIDTH(2)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  function automatic logic [31:0] pi(input logic [31:0] v);
    return (v << 2) + 32'h0000_1000;
  endfunction
  function automatic logic [31:0] pj(input logic [31:0] v);
    return v ^ 32'hDEAD_0000;
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] val);
    bus.in_valid       = v;
    bus.in_instruction = val;
    bus.in_pcIncr      = pi(val);
    bus.in_pcJump      = pj(val);
  endtask
  task automatic chk_head(input string tag, input logic [31:0] val);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_instr"}, bus.out_instruction, val);
    chk({tag, "_incr"}, bus.out_pcIncr, pi(val));
    chk({tag, "_jump"}, bus.out_pcJump, pj(val));
  endtask
  task automatic chk_state(input string tag, input int occ, input logic stall, input logic valid);
    chk({tag, "_occ"}, 32'(bus.occupancy), 32'(occ));
    chk({tag, "_stall"}, 32'(bus.fetch_stall), 32'(stall));
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(valid));
  endtask
  initial begin
    bus.flush = 1'b0;
    bus.decode_ready = 1'b0;
    drive(1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    chk_state("reset", 0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'(i));
      tick();
      chk_state("fill", i, 1'b0, 1'b1);
      chk_head("fill_head", 32'h1);
    end
    drive(1'b1, 32'h4);
    tick();
    chk_state("full", 4, 1'b1, 1'b1);
    drive(1'b1, 32'h5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("held", 4, 1'b1, 1'b1);
      chk_head("held_head", 32'h1);
    end
    bus.decode_ready = 1'b1;
    tick();
    chk_state("full_pop", 3, 1'b0, 1'b1);
    chk_head("full_pop_head", 32'h2);
    bus.decode_ready = 1'b0;
    tick();
    chk_state("late_push", 4, 1'b1, 1'b1);
    drive(1'b0, 32'h0);
    bus.decode_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk_head("drain", 32'(k));
      tick();
    end
    chk_state("drained", 0, 1'b0, 1'b0);
    bus.decode_ready = 1'b0;
    drive(1'b1, 32'h10);
    tick();
    chk_head("preload", 32'h10);
    bus.decode_ready = 1'b1;
    for (int v = 32'h11; v <= 32'h1A; v++) begin
      drive(1'b1, 32'(v));
      tick();
      chk_state("stream", 1, 1'b0, 1'b1);
      chk_head("stream_head", 32'(v));
    end
    bus.decode_ready = 1'b0;
    drive(1'b1, 32'h1B);
    tick();
    drive(1'b1, 32'h1C);
    tick();
    chk_state("pre_flush", 3, 1'b0, 1'b1);
    chk_head("pre_flush_head", 32'h1A);
    bus.flush = 1'b1;
    bus.decode_ready = 1'b1;
    drive(1'b1, 32'h99);
    tick();
    chk_state("flush", 0, 1'b0, 1'b0);
    bus.flush = 1'b0;
    bus.decode_ready = 1'b0;
    drive(1'b1, 32'hA);
    tick();
    chk_state("post_flush", 1, 1'b0, 1'b1);
    chk_head("post_flush_head", 32'hA);
    drive(1'b1, 32'hB);
    tick();
    chk_state("pre_reset", 2, 1'b0, 1'b1);
    reset = 1'b1;
    drive(1'b1, 32'hC);
    tick();
    chk_state("mid_reset", 0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(1'b0, 32'h0);
    tick();
    chk_state("after_reset", 0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
